// File: rtl/cpu6_pipectl_pkg.sv
// cpu6 pipeline controller shared types.
// FSM encodings and stall/flush bundle.
package cpu6_pipectl_pkg;

  localparam int CPU6_PIPECTL_STATE_SIZE = 2;
  localparam int CPU6_REGADDR_SIZE = 5;

  typedef enum logic [CPU6_PIPECTL_STATE_SIZE-1:0] {
    CPU6_PIPECTL_RUN      = 2'd0,
    CPU6_PIPECTL_DRAIN    = 2'd1,
    CPU6_PIPECTL_WAIT_RET = 2'd2
  } state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
  } ctl_t;

  localparam ctl_t CTL_NONE   = ctl_t'(6'b000000);
  localparam ctl_t CTL_FLUSH  = ctl_t'(6'b000011);
  localparam ctl_t CTL_MEM    = ctl_t'(6'b111100);
  // hold fetch/decode and bubble EX
  localparam ctl_t CTL_BUBBLE = ctl_t'(6'b110001);

endpackage

// File: rtl/cpu6_pipectl_if.sv
// cpu6 pipeline controller signal bundle.
// master = pipeline datapath, slave = controller.
interface cpu6_pipectl_if #(
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 16
);

  logic                 validD;
  logic                 empty_pipeline_reqD;
  logic [REGADDR_W-1:0] rs1D;
  logic [REGADDR_W-1:0] rs2D;
  logic                 use_rs1D;
  logic                 use_rs2D;
  logic                 validE;
  logic                 validM;
  logic                 validW;
  logic                 memtoregE;
  logic                 regwriteE;
  logic [REGADDR_W-1:0] rdE;
  logic                 redirectE;
  logic                 retire_serialW;
  logic                 mem_stall;
  logic                 cnt_clr;
  logic                 stallF;
  logic                 stallD;
  logic                 stallE;
  logic                 stallM;
  logic                 flushD;
  logic                 flushE;
  logic                 serial_busy;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output validD, empty_pipeline_reqD,
    output rs1D, rs2D, use_rs1D, use_rs2D,
    output validE, validM, validW,
    output memtoregE, regwriteE, rdE,
    output redirectE, retire_serialW,
    output mem_stall, cnt_clr,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE,
    input  serial_busy, stall_cnt
  );

  modport slave (
    input  validD, empty_pipeline_reqD,
    input  rs1D, rs2D, use_rs1D, use_rs2D,
    input  validE, validM, validW,
    input  memtoregE, regwriteE, rdE,
    input  redirectE, retire_serialW,
    input  mem_stall, cnt_clr,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE,
    output serial_busy, stall_cnt
  );

endinterface

// File: rtl/cpu6_hazard_ld.sv
// cpu6 load-use hazard comparator.
// Flags an ID source matching an in-flight EX load.
module cpu6_hazard_ld
  import cpu6_pipectl_pkg::*;
#(
  parameter int REGADDR_W = CPU6_REGADDR_SIZE
) (
  input  logic                 memtoreg_i,
  input  logic                 regwrite_i,
  input  logic [REGADDR_W-1:0] rd_i,
  input  logic [REGADDR_W-1:0] rs1_i,
  input  logic [REGADDR_W-1:0] rs2_i,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  output logic                 hazard_o
);

  logic ld_wr;
  logic hit1;
  logic hit2;

  // x0 is hardwired, so a load to it never blocks
  assign ld_wr = memtoreg_i & regwrite_i & (rd_i != '0);
  assign hit1  = use_rs1_i & (rs1_i == rd_i);
  assign hit2  = use_rs2_i & (rs2_i == rd_i);

  assign hazard_o = ld_wr & (hit1 | hit2);

endmodule

// File: rtl/cpu6_pipectl.sv
// cpu6 pipeline sequencing controller.
// Stall/flush arbitration, serialization FSM, stall counter.
module cpu6_pipectl
  import cpu6_pipectl_pkg::*;
#(
  parameter int REGADDR_W = CPU6_REGADDR_SIZE,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  cpu6_pipectl_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  ctl_t             ctl;
  logic             ld_hazard;
  logic             pipe_busy;
  logic             ser_req;

  cpu6_hazard_ld #(
    .REGADDR_W (REGADDR_W)
  ) u_hazard_ld (
    .memtoreg_i (bus.memtoregE),
    .regwrite_i (bus.regwriteE),
    .rd_i       (bus.rdE),
    .rs1_i      (bus.rs1D),
    .rs2_i      (bus.rs2D),
    .use_rs1_i  (bus.use_rs1D),
    .use_rs2_i  (bus.use_rs2D),
    .hazard_o   (ld_hazard)
  );

  assign pipe_busy = bus.validE | bus.validM | bus.validW;
  assign ser_req   = bus.validD & bus.empty_pipeline_reqD;

  always_comb begin
    ctl     = CTL_NONE;
    state_d = state_q;
    if (!reset) begin
      ctl = CTL_FLUSH;
    end else if (bus.mem_stall) begin
      ctl = CTL_MEM;
    end else if (bus.redirectE) begin
      ctl = CTL_FLUSH;
      // a redirect kills the instruction waiting to drain
      if (state_q == CPU6_PIPECTL_DRAIN)
        state_d = CPU6_PIPECTL_RUN;
    end else begin
      unique case (state_q)
        CPU6_PIPECTL_RUN: begin
          if (ser_req) begin
            if (pipe_busy) begin
              ctl     = CTL_BUBBLE;
              state_d = CPU6_PIPECTL_DRAIN;
            end else begin
              state_d = CPU6_PIPECTL_WAIT_RET;
            end
          end else if (ld_hazard) begin
            ctl = CTL_BUBBLE;
          end
        end
        CPU6_PIPECTL_DRAIN: begin
          if (pipe_busy)
            ctl = CTL_BUBBLE;
          else
            state_d = CPU6_PIPECTL_WAIT_RET;
        end
        CPU6_PIPECTL_WAIT_RET: begin
          if (bus.retire_serialW)
            state_d = CPU6_PIPECTL_RUN;
          else
            ctl = CTL_BUBBLE;
        end
        default: state_d = CPU6_PIPECTL_RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)
      cnt_d = '0;
    else if (ctl.stallD && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CPU6_PIPECTL_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stallF      = ctl.stallF;
  assign bus.stallD      = ctl.stallD;
  assign bus.stallE      = ctl.stallE;
  assign bus.stallM      = ctl.stallM;
  assign bus.flushD      = ctl.flushD;
  assign bus.flushE      = ctl.flushE;
  assign bus.serial_busy = (state_q != CPU6_PIPECTL_RUN);
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu6_pipectl.sv
// cpu6_pipectl bench: per-scenario tasks,
// expected outputs queued at drive, popped at sample.
module tb_cpu6_pipectl;
  import cpu6_pipectl_pkg::*;

  // {stallF,stallD,stallE,stallM,flushD,flushE,busy}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] B  = 7'b0000001;
  localparam logic [6:0] S  = 7'b1100010;
  localparam logic [6:0] SB = 7'b1100011;
  localparam logic [6:0] M  = 7'b1111000;
  localparam logic [6:0] MB = 7'b1111001;
  localparam logic [6:0] R  = 7'b0000110;
  localparam logic [6:0] RB = 7'b0000111;

  // {vD,epr,vE,vM,vW,redir,ret,ms,clr} + expected ctl
  typedef struct packed {
    logic       vD, epr, vE, vM, vW;
    logic       redir, ret, ms, clr;
    logic [6:0] ctl;
  } row_t;

  typedef struct packed {
    logic       m2r, rw;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [6:0] ctl;
  } ld_t;

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;
  logic [15:0] mcnt = '0;
  exp_t        sb[$];
  exp_t        e;
  logic [6:0]  obs;

  always #5 clk = ~clk;

  cpu6_pipectl_if #(.REGADDR_W(5), .CNT_W(16)) bus ();

  cpu6_pipectl #(
    .REGADDR_W (5),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.stallF, bus.stallD, bus.stallE,
                bus.stallM, bus.flushD, bus.flushE,
                bus.serial_busy};

  task automatic set_ld(input ld_t l);
    bus.memtoregE = l.m2r;
    bus.regwriteE = l.rw;
    bus.rdE       = l.rd;
    bus.rs1D      = l.rs1;
    bus.rs2D      = l.rs2;
    bus.use_rs1D  = l.u1;
    bus.use_rs2D  = l.u2;
  endtask

  task automatic apply(input row_t r, input string nm);
    exp_t x;
    bus.validD              = r.vD;
    bus.empty_pipeline_reqD = r.epr;
    bus.validE              = r.vE;
    bus.validM              = r.vM;
    bus.validW              = r.vW;
    bus.redirectE           = r.redir;
    bus.retire_serialW      = r.ret;
    bus.mem_stall           = r.ms;
    bus.cnt_clr             = r.clr;
    x.ctl = r.ctl;
    x.cnt = mcnt;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic advance(input row_t r);
    if (!reset || r.clr)
      mcnt = '0;
    else if (r.ctl[5] && mcnt != 16'hFFFF)
      mcnt = mcnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[3];
    rows[0] = row_t'({9'b000000000, R});
    rows[1] = row_t'({9'b000001010, R});
    rows[2] = row_t'({9'b000000000, Z});
    set_ld('0);
    for (int i = 0; i < 3; i++) begin
      reset = (i >= 2);
      apply(rows[i], "reset");
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_load_use();
    ld_t  t[8];
    row_t r;
    t[0] = ld_t'({2'b11, 5'd5, 5'd0, 5'd5, 2'b01, S});
    t[1] = ld_t'({2'b00, 5'd0, 5'd0, 5'd0, 2'b00, Z});
    t[2] = ld_t'({2'b11, 5'd0, 5'd0, 5'd0, 2'b01, Z});
    t[3] = ld_t'({2'b11, 5'd7, 5'd7, 5'd0, 2'b10, S});
    t[4] = ld_t'({2'b11, 5'd7, 5'd7, 5'd0, 2'b00, Z});
    t[5] = ld_t'({2'b10, 5'd7, 5'd7, 5'd0, 2'b10, Z});
    t[6] = ld_t'({2'b01, 5'd5, 5'd0, 5'd5, 2'b01, Z});
    t[7] = ld_t'({2'b11, 5'd9, 5'd3, 5'd4, 2'b11, Z});
    for (int i = 0; i < 8; i++) begin
      r = row_t'({9'b100000000, t[i].ctl});
      apply(r, "load_use");
      set_ld(t[i]);
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      advance(r);
    end
    set_ld('0);
  endtask

  task automatic test_serialize();
    row_t rows[13];
    rows[0]  = row_t'({9'b111110000, S});
    rows[1]  = row_t'({9'b110110000, SB});
    rows[2]  = row_t'({9'b110010000, SB});
    rows[3]  = row_t'({9'b110000000, B});
    rows[4]  = row_t'({9'b001000000, SB});
    rows[5]  = row_t'({9'b000100000, SB});
    rows[6]  = row_t'({9'b000010100, B});
    rows[7]  = row_t'({9'b000000000, Z});
    rows[8]  = row_t'({9'b110000000, Z});
    rows[9]  = row_t'({9'b110000100, B});
    rows[10] = row_t'({9'b110000000, Z});
    rows[11] = row_t'({9'b000000100, B});
    rows[12] = row_t'({9'b000000000, Z});
    for (int i = 0; i < 13; i++) begin
      apply(rows[i], "serialize");
      // a load-use match in WAIT_RET must not change anything
      if (i == 4)
        set_ld(ld_t'({2'b11, 5'd5, 5'd5, 5'd0, 2'b10, Z}));
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      set_ld('0);
      advance(rows[i]);
    end
  endtask

  task automatic test_redirect();
    row_t rows[8];
    rows[0] = row_t'({9'b111000000, S});
    rows[1] = row_t'({9'b111001000, RB});
    rows[2] = row_t'({9'b000000000, Z});
    rows[3] = row_t'({9'b110000000, Z});
    rows[4] = row_t'({9'b000001000, RB});
    rows[5] = row_t'({9'b000000000, SB});
    rows[6] = row_t'({9'b000000100, B});
    rows[7] = row_t'({9'b000000000, Z});
    for (int i = 0; i < 8; i++) begin
      apply(rows[i], "redirect");
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_mem_stall();
    row_t rows[12];
    for (int i = 0; i < 4; i++)
      rows[i] = row_t'({9'b000001010, M});
    rows[4]  = row_t'({9'b000001000, R});
    rows[5]  = row_t'({9'b000000000, Z});
    rows[6]  = row_t'({9'b111000000, S});
    rows[7]  = row_t'({9'b000000010, MB});
    rows[8]  = row_t'({9'b000000010, MB});
    rows[9]  = row_t'({9'b000000000, B});
    rows[10] = row_t'({9'b000000100, B});
    rows[11] = row_t'({9'b000000000, Z});
    for (int i = 0; i < 12; i++) begin
      apply(rows[i], "mem_stall");
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      advance(rows[i]);
    end
  endtask

  task automatic test_saturate();
    row_t hold;
    row_t rows[4];
    hold = row_t'({9'b000000010, M});
    for (int i = 0; i < 65539; i++) begin
      apply(hold, "sat_fill");
      void'(sb.pop_front());
      advance(hold);
    end
    rows[0] = row_t'({9'b000000010, M});
    rows[1] = row_t'({9'b000000011, M});
    rows[2] = row_t'({9'b000000000, Z});
    rows[3] = row_t'({9'b000000001, Z});
    for (int i = 0; i < 4; i++) begin
      apply(rows[i], "saturate");
      #3;
      e = sb.pop_front();
      n_run++;
      if ({obs, bus.stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 e.nm, i, obs, bus.stall_cnt, e.ctl, e.cnt);
      end
      advance(rows[i]);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_serialize();
    test_redirect();
    test_mem_stall();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
